// File: rtl/sliding_window_buffer.sv
// Parametrised KxK pixel window for the Sobel pipeline: command-driven full load or one-lane shift,
// then valid/ready refill of the vacated lane. Define WINDOW_REPLICATE_EN to edge-replicate on shift.
module sliding_window_buffer #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned WIN_K = 3
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           cmd_valid,
  input  logic [1:0]                     cmd_op,
  output logic                           cmd_ready,
  input  logic                           pix_valid,
  input  logic [PIX_W-1:0]               pix_data,
  output logic                           pix_ready,
  output logic                           shift_done,
  output logic                           load_done,
  output logic                           win_valid,
  output logic [WIN_K*WIN_K*PIX_W-1:0]   win_out
);

  localparam int unsigned NPIX  = WIN_K * WIN_K;
  localparam int unsigned CNT_W = $clog2(NPIX + 1);
  localparam int unsigned IDX_W = $clog2(NPIX);

  localparam logic [1:0] OP_FULL  = 2'b00;
  localparam logic [1:0] OP_LEFT  = 2'b01;
  localparam logic [1:0] OP_RIGHT = 2'b10;
  localparam logic [1:0] OP_DOWN  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LOAD, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic [1:0]                   op_q, op_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [NPIX-1:0][PIX_W-1:0]   win_q, win_d;
  logic                         win_valid_q, win_valid_d;
  logic                         cmd_ready_q, cmd_ready_d;
  logic                         pix_ready_q, pix_ready_d;
  logic                         shift_done_q, shift_done_d;
  logic                         load_done_q, load_done_d;

  int unsigned                  cnt_u;
  int unsigned                  last_u;
  logic [IDX_W-1:0]             tgt_idx;

  assign cnt_u  = 32'(cnt_q);
  assign last_u = (op_q == OP_FULL) ? NPIX - 1 : WIN_K - 1;

  // Fill order: full load goes bottom row first; shifts refill the vacated lane.
  always_comb begin
    case (op_q)
      OP_FULL:  tgt_idx = IDX_W'((WIN_K - 1 - cnt_u / WIN_K) * WIN_K + cnt_u % WIN_K);
      OP_LEFT:  tgt_idx = IDX_W'((WIN_K - 1 - cnt_u) * WIN_K + WIN_K - 1);
      OP_RIGHT: tgt_idx = IDX_W'((WIN_K - 1 - cnt_u) * WIN_K);
      default:  tgt_idx = IDX_W'(cnt_u);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d        = cmd_op;
          win_valid_d = 1'b0;
          state_d     = (cmd_op == OP_FULL) ? S_LOAD : S_SHIFT;
        end
      end
      S_SHIFT: begin
        for (int unsigned r = 0; r < WIN_K; r++) begin
          for (int unsigned c = 0; c < WIN_K; c++) begin
            case (op_q)
              OP_LEFT: begin
                if (c < WIN_K - 1)
                  win_d[IDX_W'(r*WIN_K + c)] = win_q[IDX_W'(r*WIN_K + c + 1)];
                else
`ifdef WINDOW_REPLICATE_EN
                  win_d[IDX_W'(r*WIN_K + c)] = win_q[IDX_W'(r*WIN_K + c)];
`else
                  win_d[IDX_W'(r*WIN_K + c)] = '0;
`endif
              end
              OP_RIGHT: begin
                if (c > 0)
                  win_d[IDX_W'(r*WIN_K + c)] = win_q[IDX_W'(r*WIN_K + c - 1)];
                else
`ifdef WINDOW_REPLICATE_EN
                  win_d[IDX_W'(r*WIN_K + c)] = win_q[IDX_W'(r*WIN_K)];
`else
                  win_d[IDX_W'(r*WIN_K + c)] = '0;
`endif
              end
              OP_DOWN: begin
                if (r > 0)
                  win_d[IDX_W'(r*WIN_K + c)] = win_q[IDX_W'((r - 1)*WIN_K + c)];
                else
`ifdef WINDOW_REPLICATE_EN
                  win_d[IDX_W'(c)] = win_q[IDX_W'(c)];
`else
                  win_d[IDX_W'(c)] = '0;
`endif
              end
              default: ;
            endcase
          end
        end
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (pix_valid) begin
          win_d[tgt_idx] = pix_data;
          if (cnt_u == last_u) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        win_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d  = (state_d == S_IDLE);
    pix_ready_d  = (state_d == S_LOAD);
    shift_done_d = (state_q == S_SHIFT);
    load_done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_FULL;
      cnt_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      cmd_ready_q  <= 1'b1;
      pix_ready_q  <= 1'b0;
      shift_done_q <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      cmd_ready_q  <= cmd_ready_d;
      pix_ready_q  <= pix_ready_d;
      shift_done_q <= shift_done_d;
      load_done_q  <= load_done_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign pix_ready  = pix_ready_q;
  assign shift_done = shift_done_q;
  assign load_done  = load_done_q;
  assign win_valid  = win_valid_q;
  assign win_out    = win_q;

endmodule

// File: tb/tb_sliding_window_buffer.sv
// Bench for sliding_window_buffer: K=3 and K=5 instances, directed table plus random ops vs a window model.
module tb_sliding_window_buffer;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic       cmd_valid_a [2];
  logic [1:0] cmd_op_a    [2];
  logic       pix_valid_a [2];
  logic [7:0] pix_data_a  [2];
  logic       cmd_ready_a [2];
  logic       pix_ready_a [2];
  logic       shift_done_a[2];
  logic       load_done_a [2];
  logic       win_valid_a [2];
  logic [71:0]  win3;
  logic [199:0] win5;

  sliding_window_buffer #(.PIX_W(8), .WIN_K(3)) u_k3 (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid_a[0]), .cmd_op(cmd_op_a[0]), .cmd_ready(cmd_ready_a[0]),
    .pix_valid(pix_valid_a[0]), .pix_data(pix_data_a[0]), .pix_ready(pix_ready_a[0]),
    .shift_done(shift_done_a[0]), .load_done(load_done_a[0]), .win_valid(win_valid_a[0]),
    .win_out(win3)
  );

  sliding_window_buffer #(.PIX_W(8), .WIN_K(5)) u_k5 (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid_a[1]), .cmd_op(cmd_op_a[1]), .cmd_ready(cmd_ready_a[1]),
    .pix_valid(pix_valid_a[1]), .pix_data(pix_data_a[1]), .pix_ready(pix_ready_a[1]),
    .shift_done(shift_done_a[1]), .load_done(load_done_a[1]), .win_valid(win_valid_a[1]),
    .win_out(win5)
  );

  int total = 0;
  int bad   = 0;
  int kk[2] = '{3, 5};
  int mdl[2][25];

  typedef struct {
    logic [1:0]  op;
    int          pix[9];
    logic [71:0] exp;
    int          mode;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [199:0] win(input int w);
    return (w == 0) ? {128'd0, win3} : win5;
  endfunction

  function automatic logic [71:0] pk(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    return {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  // Raster index (r*K+c) that the n-th accepted pixel lands on.
  function automatic int tgt(input int k, input logic [1:0] op, input int n);
    case (op)
      2'b00:   return (k - 1 - n / k) * k + n % k;
      2'b01:   return (k - 1 - n) * k + (k - 1);
      2'b10:   return (k - 1 - n) * k;
      default: return n;
    endcase
  endfunction

  function automatic int fill(input int v);
`ifdef WINDOW_REPLICATE_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic model_shift(input int w, input logic [1:0] op);
    int k = kk[w];
    int o[25];
    o = mdl[w];
    for (int r = 0; r < k; r++)
      for (int c = 0; c < k; c++)
        case (op)
          2'b01: mdl[w][r*k+c] = (c < k-1) ? o[r*k+c+1] : fill(o[r*k+c]);
          2'b10: mdl[w][r*k+c] = (c > 0) ? o[r*k+c-1] : fill(o[r*k]);
          2'b11: mdl[w][r*k+c] = (r > 0) ? o[(r-1)*k+c] : fill(o[c]);
          default: ;
        endcase
  endtask

  function automatic logic [199:0] mdl_flat(input int w);
    logic [199:0] f = '0;
    for (int i = 0; i < kk[w]*kk[w]; i++) f[i*8 +: 8] = 8'(mdl[w][i]);
    return f;
  endfunction

  function automatic void mdl_clear();
    for (int w = 0; w < 2; w++) for (int i = 0; i < 25; i++) mdl[w][i] = 0;
  endfunction

  // mode bits: 1 gap every other cycle, 2 random gaps, 4 stray cmd in gaps, 8 pixel with the cmd
  task automatic run(input int w, input logic [1:0] op, input int pix[25], input int mode);
    int  k = kk[w];
    int  n = (op == 2'b00) ? k*k : k;
    bit  gap;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready_a[w], 1);
    cmd_valid_a[w] = 1'b1;
    cmd_op_a[w]    = op;
    if ((mode & 8) != 0) begin
      pix_valid_a[w] = 1'b1;
      pix_data_a[w]  = 8'hEE;
    end
    @(negedge clk);
    cmd_valid_a[w] = 1'b0;
    pix_valid_a[w] = 1'b0;
    chk("win_valid_drop", win_valid_a[w], 0);
    if (op != 2'b00) begin
      chk("shift_pix_ready", pix_ready_a[w], 0);
      chk("shift_done_early", shift_done_a[w], 0);
      model_shift(w, op);
      @(negedge clk);
      chk("shift_done", shift_done_a[w], 1);
      chk("shifted_win", win(w), mdl_flat(w));
    end
    chk("load_pix_ready", pix_ready_a[w], 1);
    for (int i = 0; i < n; i++) begin
      gap = (((mode & 1) != 0) && i > 0) || (((mode & 2) != 0) && $urandom_range(1, 0) == 1);
      if (gap) begin
        if ((mode & 4) != 0) begin
          cmd_valid_a[w] = 1'b1;
          cmd_op_a[w]    = 2'b01;
        end
        @(negedge clk);
        if ((mode & 4) != 0) chk("cmd_ready_load", cmd_ready_a[w], 0);
        cmd_valid_a[w] = 1'b0;
      end
      pix_valid_a[w] = 1'b1;
      pix_data_a[w]  = 8'(pix[i]);
      @(negedge clk);
      pix_valid_a[w] = 1'b0;
      mdl[w][tgt(k, op, i)] = pix[i];
    end
    chk("load_done", load_done_a[w], 1);
    chk("done_pix_ready", pix_ready_a[w], 0);
    @(negedge clk);
    chk("load_done_pulse", load_done_a[w], 0);
    chk("win_valid", win_valid_a[w], 1);
    chk("cmd_ready_back", cmd_ready_a[w], 1);
    chk("window", win(w), mdl_flat(w));
  endtask

  initial begin
    int p[25];
    for (int w = 0; w < 2; w++) begin
      cmd_valid_a[w] = 1'b0;
      cmd_op_a[w]    = 2'b00;
      pix_valid_a[w] = 1'b0;
      pix_data_a[w]  = 8'h00;
    end
    mdl_clear();

    vecs[0] = '{op: 2'b00, pix: '{1, 2, 3, 4, 5, 6, 7, 8, 9},
                exp: pk(7, 8, 9, 4, 5, 6, 1, 2, 3), mode: 0};
    vecs[1] = '{op: 2'b01, pix: '{10, 11, 12, 0, 0, 0, 0, 0, 0},
                exp: pk(8, 9, 12, 5, 6, 11, 2, 3, 10), mode: 0};
    vecs[2] = '{op: 2'b00, pix: '{1, 2, 3, 4, 5, 6, 7, 8, 9},
                exp: pk(7, 8, 9, 4, 5, 6, 1, 2, 3), mode: 1 | 4 | 8};
    vecs[3] = '{op: 2'b11, pix: '{20, 21, 22, 0, 0, 0, 0, 0, 0},
                exp: pk(20, 21, 22, 7, 8, 9, 4, 5, 6), mode: 1};

    #12;
    chk("rst_pix_ready", pix_ready_a[0], 0);
    chk("rst_shift_done", shift_done_a[0], 0);
    chk("rst_load_done", load_done_a[0], 0);
    chk("rst_win_valid", win_valid_a[0], 0);
    chk("rst_win", win(0), 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready_a[0], 1);

    for (int v = 0; v < 4; v++) begin
      p = '{default: 0};
      for (int i = 0; i < 9; i++) p[i] = vecs[v].pix[i];
      run(0, vecs[v].op, p, vecs[v].mode);
      chk("table_window", win(0), {128'd0, vecs[v].exp});
    end

    // Pixels offered in IDLE must be dropped.
    @(negedge clk);
    pix_valid_a[0] = 1'b1;
    pix_data_a[0]  = 8'h55;
    @(negedge clk);
    @(negedge clk);
    pix_valid_a[0] = 1'b0;
    chk("idle_pix_ready", pix_ready_a[0], 0);
    chk("idle_pix_ignored", win(0), {128'd0, vecs[3].exp});

    // Reset part-way through a full load.
    @(negedge clk);
    cmd_valid_a[0] = 1'b1;
    cmd_op_a[0]    = 2'b00;
    @(negedge clk);
    cmd_valid_a[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pix_valid_a[0] = 1'b1;
      pix_data_a[0]  = 8'(40 + i);
      @(negedge clk);
    end
    pix_valid_a[0] = 1'b0;
    n_rst = 1'b0;
    #1;
    chk("midrst_win", win(0), 0);
    chk("midrst_pix_ready", pix_ready_a[0], 0);
    chk("midrst_load_done", load_done_a[0], 0);
    chk("midrst_win_valid", win_valid_a[0], 0);
    mdl_clear();
    @(negedge clk);
    n_rst = 1'b1;
    p = '{default: 0};
    for (int i = 0; i < 9; i++) p[i] = i + 1;
    run(0, 2'b00, p, 0);
    chk("after_rst_window", win(0), {128'd0, vecs[0].exp});

    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 25; i++) p[i] = int'($urandom_range(255, 0));
      run(0, 2'($urandom_range(3, 0)), p, 2);
    end

    for (int i = 0; i < 25; i++) p[i] = i + 1;
    run(1, 2'b00, p, 0);
    chk("k5_first_pix", win5[20*8 +: 8], 1);
    chk("k5_last_pix", win5[4*8 +: 8], 25);
    for (int i = 0; i < 5; i++) p[i] = 26 + i;
    run(1, 2'b01, p, 0);
    chk("k5_left_bottom", win5[24*8 +: 8], 26);
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 25; i++) p[i] = int'($urandom_range(255, 0));
      run(1, 2'($urandom_range(3, 0)), p, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
